// File: rtl/mx_pkg.sv
// rtl/mx_pkg.sv - shared state type, frame constants and CRC-8 helper for mx_frame_ctrl
// The CRC helper is only referenced when MX_FRAME_CRC_EN is defined.
package mx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_LEN,
      ST_PAYLOAD,
      ST_CRC,
      ST_DONE
   } mx_state_t;

   localparam logic [7:0] MX_PREAMBLE = 8'h55;
   localparam logic [7:0] MX_CRC_POLY = 8'h07;

   // One byte of CRC-8, MSB-first, no reflection.
   function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ MX_CRC_POLY) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/mx_byte_fifo.sv
// rtl/mx_byte_fifo.sv - payload byte FIFO with occupancy count
// A push while full is accepted only when a pop happens in the same cycle.
module mx_byte_fifo #(
   parameter int DEPTH = 16,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mx_frame_ctrl.sv
// rtl/mx_frame_ctrl.sv - frames buffered payload as preamble/SFD/LEN/payload[/CRC] bytes
// Optional trailing CRC-8 byte enabled by defining MX_FRAME_CRC_EN.
module mx_frame_ctrl
   import mx_pkg::*;
#(
   parameter int         PREAMBLE_BYTES = 2,
   parameter logic [7:0] SFD_BYTE       = 8'hD5,
   parameter int         DEPTH          = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       full,
   input  logic       send,
   output logic       busy,
   output logic       done,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   input  logic       tx_rdy
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [3:0] PRE_N = 4'(PREAMBLE_BYTES);

   mx_state_t     state;
   logic [3:0]    pre_cnt;
   logic [CW-1:0] len;
   logic [CW-1:0] left;
   logic [7:0]    byte_q;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty;
   logic          hs;
   logic          pop;
`ifdef MX_FRAME_CRC_EN
   logic [7:0]    crc;
`endif

   assign hs  = tx_valid && tx_rdy;
   assign pop = hs && (state == ST_PAYLOAD);

   // Payload bytes come straight from the FIFO head so the next byte is ready right after a pop.
   assign tx_data = (state == ST_PAYLOAD) ? fifo_dout : byte_q;

   mx_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_en),
      .pop   (pop),
      .din   (wr_data),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         pre_cnt  <= '0;
         len      <= '0;
         left     <= '0;
         byte_q   <= '0;
         tx_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef MX_FRAME_CRC_EN
         crc      <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (send && !fifo_empty) begin
                  len      <= fifo_count;
                  left     <= fifo_count;
                  pre_cnt  <= 4'd1;
                  byte_q   <= MX_PREAMBLE;
                  tx_valid <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ST_PREAMBLE;
`ifdef MX_FRAME_CRC_EN
                  crc      <= '0;
`endif
               end
            end
            ST_PREAMBLE: begin
               if (hs) begin
                  if (pre_cnt == PRE_N) begin
                     byte_q <= SFD_BYTE;
                     state  <= ST_SFD;
                  end else begin
                     pre_cnt <= pre_cnt + 4'd1;
                  end
               end
            end
            ST_SFD: begin
               if (hs) begin
                  byte_q <= 8'(len);
                  state  <= ST_LEN;
               end
            end
            ST_LEN: begin
               if (hs) begin
                  state <= ST_PAYLOAD;
`ifdef MX_FRAME_CRC_EN
                  crc   <= crc8_update(crc, byte_q);
`endif
               end
            end
            ST_PAYLOAD: begin
               if (hs) begin
                  left <= left - CW'(1);
`ifdef MX_FRAME_CRC_EN
                  crc  <= crc8_update(crc, fifo_dout);
`endif
                  if (left == CW'(1)) begin
`ifdef MX_FRAME_CRC_EN
                     byte_q   <= crc8_update(crc, fifo_dout);
                     state    <= ST_CRC;
`else
                     tx_valid <= 1'b0;
                     done     <= 1'b1;
                     state    <= ST_DONE;
`endif
                  end
               end
            end
`ifdef MX_FRAME_CRC_EN
            ST_CRC: begin
               if (hs) begin
                  tx_valid <= 1'b0;
                  done     <= 1'b1;
                  state    <= ST_DONE;
               end
            end
`endif
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               tx_valid <= 1'b0;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mx_frame_ctrl.sv
// tb/tb_mx_frame_ctrl.sv - randomized self-checking bench for mx_frame_ctrl against a queue model
// Define MX_FRAME_CRC_EN to check the CRC build.
module tb_mx_frame_ctrl;

   localparam int PRE   = 2;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       full;
   logic       send = 1'b0;
   logic       busy;
   logic       done;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_rdy = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int n_done   = 0;

   // Model: byte queue for the FIFO, the full byte list of the current frame, and a frame phase.
   byte unsigned m_fifo[$];
   byte unsigned m_frame[$];
   byte unsigned obs[$];
   byte unsigned exp_q[$];
   int m_phase = 0;   // 0 idle, 1 sending, 2 done cycle
   int m_pos   = 0;
   int m_plen  = 0;

   mx_frame_ctrl #(.PREAMBLE_BYTES(PRE), .SFD_BYTE(8'hD5), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .send     (send),
      .busy     (busy),
      .done     (done),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_rdy   (tx_rdy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Bit-serial CRC-8 over the whole message, poly x^8+x^2+x+1.
   function automatic byte unsigned ref_crc(input byte unsigned msg[$]);
      logic [7:0] c = 8'h00;
      logic fb;
      foreach (msg[i]) begin
         for (int b = 7; b >= 0; b--) begin
            fb = c[7] ^ msg[i][b];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
         end
      end
      return c;
   endfunction

   function automatic void build_frame();
      byte unsigned crc_msg[$];
      m_frame.delete();
      m_plen = m_fifo.size();
      for (int i = 0; i < PRE; i++) m_frame.push_back(8'h55);
      m_frame.push_back(8'hD5);
      m_frame.push_back(8'(m_plen));
      crc_msg.push_back(8'(m_plen));
      for (int i = 0; i < m_plen; i++) begin
         m_frame.push_back(m_fifo[i]);
         crc_msg.push_back(m_fifo[i]);
      end
`ifdef MX_FRAME_CRC_EN
      m_frame.push_back(ref_crc(crc_msg));
`endif
   endfunction

   // One clock: check outputs against the model, drive inputs, then advance the model at the edge.
   task automatic cycle(input logic r, input logic we, input logic [7:0] wd, input logic snd, input logic rdy);
      bit pop;
      @(negedge clk);
      check("tx_valid", tx_valid, m_phase == 1);
      check("busy", busy, m_phase != 0);
      check("done", done, m_phase == 2);
      check("full", full, m_fifo.size() == DEPTH);
      if (m_phase == 1) check("tx_data", tx_data, m_frame[m_pos]);
      if (done) n_done++;
      rst = r; wr_en = we; wr_data = wd; send = snd; tx_rdy = rdy;
      if (tx_valid && rdy && !r) obs.push_back(tx_data);
      @(posedge clk);
      pop = 0;
      if (r) begin
         m_fifo.delete();
         m_phase = 0;
         m_pos = 0;
      end else begin
         case (m_phase)
            0: if (snd && m_fifo.size() > 0) begin
                  build_frame();
                  m_phase = 1;
                  m_pos = 0;
               end
            1: if (rdy) begin
                  if (m_pos >= PRE + 2 && m_pos < PRE + 2 + m_plen) pop = 1;
                  m_pos++;
                  if (m_pos == m_frame.size()) m_phase = 2;
               end
            default: m_phase = 0;
         endcase
         if (pop) void'(m_fifo.pop_front());
         if (we && (m_fifo.size() < DEPTH || pop)) m_fifo.push_back(wd);
      end
   endtask

   task automatic compare_obs(input string tag);
      check({tag, "_count"}, obs.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) check(tag, obs[i], exp_q[i]);
   endtask

   task automatic expect_frame(input byte unsigned pay[$]);
      byte unsigned msg[$];
      exp_q.delete();
      for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      exp_q.push_back(8'(pay.size()));
      msg.push_back(8'(pay.size()));
      foreach (pay[i]) begin
         exp_q.push_back(pay[i]);
         msg.push_back(pay[i]);
      end
`ifdef MX_FRAME_CRC_EN
      exp_q.push_back(ref_crc(msg));
`endif
   endtask

   initial begin
      byte unsigned pay[$];
      int d0;
      bit hit;

      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      @(negedge clk);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_full", full, 0);
      check("rst_tx_data", tx_data, 8'h00);

      // Send with an empty FIFO is ignored.
      cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 1);
      check("empty_send_busy", busy, 0);

      // Basic frame, ready always high, with a second send mid-frame.
      pay = '{8'hA1, 8'hA2, 8'hA3};
      foreach (pay[i]) cycle(0, 1, pay[i], 0, 1);
      obs.delete(); d0 = n_done;
      cycle(0, 0, 0, 1, 1);
      for (int i = 0; i < 16; i++) cycle(0, 0, 0, i == 3, 1);
      expect_frame(pay);
      compare_obs("basic");
      check("basic_done_pulses", n_done - d0, 1);

      // Same frame with random stalls.
      foreach (pay[i]) cycle(0, 1, pay[i], 0, 1);
      obs.delete(); d0 = n_done;
      cycle(0, 0, 0, 1, 0);
      for (int i = 0; i < 60; i++) cycle(0, 0, 0, 0, 1'($urandom));
      for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, 1);
      compare_obs("stall");
      check("stall_done_pulses", n_done - d0, 1);

      // Overfill: 17 writes, the last one dropped; LEN = DEPTH.
      for (int i = 0; i <= DEPTH; i++) begin
         cycle(0, 1, 8'(i), 0, 0);
         if (i == DEPTH - 1) begin
            @(negedge clk);
            check("full_after_16", full, 1);
         end
      end
      pay.delete();
      for (int i = 0; i < DEPTH; i++) pay.push_back(8'(i));
      obs.delete();
      cycle(0, 0, 0, 1, 1);
      for (int i = 0; i < 30; i++) cycle(0, 0, 0, 0, 1);
      expect_frame(pay);
      compare_obs("full_frame");
      check("fifo_empty_after", m_fifo.size(), 0);

      // Random traffic including writes during frames and sends while busy.
      for (int i = 0; i < 600; i++)
         cycle(0, ($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
      for (int i = 0; i < 60; i++) cycle(0, 0, 0, 0, 1);

      // Reset in the middle of the payload.
      for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'hB0 + i), 0, 0);
      cycle(0, 0, 0, 1, 1);
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         cycle(0, 0, 0, 0, 1);
         if (m_phase == 1 && m_pos > PRE + 3) hit = 1;
      end
      check("reach_payload", hit, 1);
      d0 = n_done;
      cycle(1, 0, 0, 0, 0);
      @(negedge clk);
      check("abort_tx_valid", tx_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_full", full, 0);
      check("abort_done", done, 0);
      cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      check("abort_send_ignored", busy, 0);
      check("abort_no_done", n_done - d0, 0);

`ifdef MX_FRAME_CRC_EN
      cycle(0, 1, 8'h01, 0, 0);
      obs.delete();
      cycle(0, 0, 0, 1, 1);
      for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, 1);
      exp_q = '{8'h55, 8'h55, 8'hD5, 8'h01, 8'h01, 8'h12};
      compare_obs("crc_frame");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/mx_frame_ctrl.md
MX_FRAME_CTRL -- requirements
Module: mx_frame_ctrl

Interface
REQ-001 SHALL have parameter PREAMBLE_BYTES, default 2, meaning the number of 8'h55 bytes sent before the SFD (range 1..15).
REQ-002 SHALL have parameter SFD_BYTE, default 8'hD5, meaning the start-of-frame delimiter byte.
REQ-003 SHALL have parameter DEPTH, default 16, meaning the payload FIFO depth in bytes and the maximum frame length.
REQ-004 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port wr_en  input  1  payload byte write strobe.
REQ-007 SHALL have port wr_data  input  8  payload byte.
REQ-008 SHALL have port full  output  1  FIFO holds DEPTH bytes.
REQ-009 SHALL have port send  input  1  single-cycle frame start request.
REQ-010 SHALL have port busy  output  1  frame in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-012 SHALL have port tx_valid  output  1  byte offered to the Manchester byte transmitter.
REQ-013 SHALL have port tx_data  output  8  offered byte.
REQ-014 SHALL have port tx_rdy  input  1  transmitter accepts a byte this cycle.

Function
REQ-015 SHALL transfer a byte only in a cycle where tx_valid and tx_rdy are both 1; tx_data SHALL hold stable while tx_valid=1 and tx_rdy=0.
REQ-016 SHALL implement states IDLE, PREAMBLE, SFD, LEN, PAYLOAD, CRC, DONE.
REQ-017 IDLE: on send=1 with FIFO count>0 and not busy, SHALL capture len=count and go to PREAMBLE; send with an empty FIFO SHALL be ignored.
REQ-018 PREAMBLE SHALL offer 8'h55 PREAMBLE_BYTES times, then go to SFD.
REQ-019 SFD SHALL offer SFD_BYTE once; LEN SHALL offer len zero-extended to 8 bits.
REQ-020 PAYLOAD SHALL offer the FIFO head, pop it on each handshake, and leave after exactly len handshakes.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE; tx_valid SHALL be 1 only in PREAMBLE, SFD, LEN, PAYLOAD and CRC.
REQ-023 send while busy SHALL be ignored and SHALL NOT be queued.
REQ-024 wr_en with full=1 SHALL drop the byte and leave the FIFO unchanged.
REQ-025 Writes during a frame SHALL be accepted into the FIFO and held for the next frame, and SHALL NOT change the captured len.
REQ-026 A simultaneous pop and write SHALL leave count unchanged and SHALL be legal when the FIFO is full.
REQ-027 The FIFO count SHALL be $clog2(DEPTH+1) bits wide, and the read/write pointers SHALL wrap modulo DEPTH.
REQ-028 A frame with len=DEPTH SHALL send LEN=DEPTH.
REQ-029 There SHALL be no throughput bubble: after a handshake, the next byte SHALL be offered in the following cycle.

Reset
REQ-030 On rst=1, the block SHALL enter IDLE, empty the FIFO, and clear all counters and the CRC register.
REQ-031 The outputs SHALL be 0 in the cycle after rst is sampled: tx_valid, busy, done, full and tx_data=8'h00.
REQ-032 rst SHALL abort a frame in progress immediately, with no DONE pulse.

Configuration
REQ-033 With macro MX_FRAME_CRC_EN defined, PAYLOAD SHALL go to CRC.
REQ-034 CRC SHALL offer a CRC-8 (polynomial 0x07, init 0x00, MSB-first, no final XOR) computed over the LEN byte and all payload bytes, then go to DONE.
REQ-035 With MX_FRAME_CRC_EN undefined, PAYLOAD SHALL go directly to DONE, and the CRC state and register SHALL NOT be synthesized.

Structure
REQ-036 Package mx_pkg SHALL hold the state enum type, the preamble constant 8'h55, and the CRC polynomial constant 8'h07.
REQ-037 The payload FIFO SHALL be sub-module mx_byte_fifo (parameter DEPTH; ports push, pop, din, dout, count, full, empty).

Verification
REQ-038 Write A1,A2,A3, then send with tx_rdy=1 -> bytes 55,55,D5,03,A1,A2,A3 [,CRC], then done=1 for one cycle, then busy=0.
REQ-039 Same frame with tx_rdy toggling pseudo-randomly -> identical byte sequence, and tx_data stable on every stalled cycle.
REQ-040 Write 17 bytes 00..10 -> full=1 after the 16th, byte 10 dropped; send -> LEN=10 (hex), payload 00..0F.
REQ-041 send with an empty FIFO -> tx_valid and busy stay 0; send during a frame -> no second frame.
REQ-042 rst during PAYLOAD -> the next cycle has tx_valid=0, busy=0, full=0 and no done pulse; a subsequent send is ignored.
REQ-043 With MX_FRAME_CRC_EN defined, payload 01 -> LEN=01 followed by CRC byte 12 (hex).
